// File: rtl/addition_initiator.sv
// Requester side of the sign-magnitude adder start/finish four-phase handshake.
// Takes a request over valid/ready, runs one adder transaction, returns result/timeout.
`timescale 1ns/1ps

// state   | meaning
// IDLE    | waiting for a request, req_ready high
// ISSUE   | start high, operands held, waiting for finish = 1
// RELEASE | start low, waiting for finish = 0 (return to zero)
// RESP    | response presented until rsp_ready
module addition_initiator #(
  parameter int TIMEOUT_CYCLES = 32,
  parameter bit NORM_NEG_ZERO  = 1'b1
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic        req_sub,
  output logic        start,
  input  logic        finish,
  output logic [15:0] INn1,
  output logic [15:0] INn2,
  output logic        sub,
  input  logic [15:0] out,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic        rsp_timeout,
  output logic [7:0]  op_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RELEASE = 2'd2,
    RESP    = 2'd3
  } state_t;

  // Terminal count: abort on the cycle that would make TIMEOUT_CYCLES spent in a wait state.
  localparam logic [7:0] TMO_TC = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        start_q, start_d;
  logic [15:0] inn1_q, inn1_d;
  logic [15:0] inn2_q, inn2_d;
  logic        sub_q, sub_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_timeout_q, rsp_timeout_d;
  logic [15:0] rsp_result_q, rsp_result_d;
  logic [7:0]  op_count_q, op_count_d;
  logic [7:0]  tmo_cnt_q, tmo_cnt_d;

  logic        tmo_hit;
  logic [15:0] out_norm;

  assign tmo_hit  = (tmo_cnt_q == TMO_TC);
  assign out_norm = (NORM_NEG_ZERO && (out == 16'h8000)) ? 16'h0000 : out;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q       <= IDLE;
      start_q       <= 1'b0;
      inn1_q        <= 16'h0000;
      inn2_q        <= 16'h0000;
      sub_q         <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_result_q  <= 16'h0000;
      op_count_q    <= 8'h00;
      tmo_cnt_q     <= 8'h00;
    end else begin
      state_q       <= state_d;
      start_q       <= start_d;
      inn1_q        <= inn1_d;
      inn2_q        <= inn2_d;
      sub_q         <= sub_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_result_q  <= rsp_result_d;
      op_count_q    <= op_count_d;
      tmo_cnt_q     <= tmo_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    start_d       = start_q;
    inn1_d        = inn1_q;
    inn2_d        = inn2_q;
    sub_d         = sub_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_timeout_d = rsp_timeout_q;
    rsp_result_d  = rsp_result_q;
    op_count_d    = op_count_q;
    tmo_cnt_d     = tmo_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          inn1_d    = req_a;
          inn2_d    = req_b;
          sub_d     = req_sub;
          start_d   = 1'b1;
          tmo_cnt_d = 8'h00;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (finish) begin
          rsp_result_d = out_norm;
          start_d      = 1'b0;
          tmo_cnt_d    = 8'h00;
          state_d      = RELEASE;
        end else if (tmo_hit) begin
          start_d       = 1'b0;
          rsp_result_d  = 16'h0000;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          state_d       = RESP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end
      RELEASE: begin
        if (!finish) begin
          rsp_valid_d   = 1'b1;
          rsp_timeout_d = 1'b0;
          op_count_d    = op_count_q + 8'd1;
          state_d       = RESP;
        end else if (tmo_hit) begin
          // Adder never returned to zero: the captured result is discarded.
          rsp_result_d  = 16'h0000;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          state_d       = RESP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready   = (state_q == IDLE);
  assign start       = start_q;
  assign INn1        = inn1_q;
  assign INn2        = inn2_q;
  assign sub         = sub_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_timeout = rsp_timeout_q;
  assign rsp_result  = rsp_result_q;
  assign op_count    = op_count_q;

endmodule

// File: doc/addition_initiator.md
Name: addition_initiator

Overview:
Requester-side controller for the 16-bit sign-magnitude adder/subtractor's start/finish four-phase handshake. It accepts an operand pair and an add/sub select from upstream over a valid/ready interface. It holds the operands stable while driving start, waits for finish, and captures the result. It then completes the return-to-zero phase and presents the result downstream over valid/ready, with a timeout flag for a non-responding adder.

Parameters:
TIMEOUT_CYCLES, 32, max cycles spent in ISSUE or RELEASE before abort; range 2..255.
NORM_NEG_ZERO, 1, when 1 a captured result of 16'h8000 is returned as 16'h0000.

Ports:
clk  input  1  system clock, all state on rising edge
RST  input  1  asynchronous active-high reset
req_valid  input  1  upstream request valid
req_ready  output  1  high only in IDLE
req_a  input  16  operand 1, sign-magnitude (bit 15 = sign)
req_b  input  16  operand 2, sign-magnitude
req_sub  input  1  1 = a - b, 0 = a + b
start  output  1  to adder start, registered
finish  input  1  from adder finish
INn1  output  16  to adder operand 1, registered
INn2  output  16  to adder operand 2, registered
sub  output  1  to adder sub, registered
out  input  16  adder result, valid while finish = 1
rsp_valid  output  1  response valid
rsp_ready  input  1  downstream accepts response
rsp_result  output  16  captured result, sign-magnitude
rsp_timeout  output  1  1 = operation aborted, rsp_result = 0
op_count  output  8  completed non-timeout operations, wraps 255 -> 0

Behaviour:
- Reset (async, RST = 1): state IDLE; start, INn1, INn2, sub, rsp_valid, rsp_timeout, rsp_result, op_count and the timeout counter all 0. start drops immediately, including mid-operation.
- States:
  - IDLE: req_ready = 1. On req_valid, latch req_a/req_b/req_sub into INn1/INn2/sub, set start = 1, clear the timeout counter, go to ISSUE.
  - ISSUE: start = 1; INn1/INn2/sub held constant. On finish = 1: rsp_result <= out (normalised if NORM_NEG_ZERO), start <= 0, clear the counter, go to RELEASE.
  - RELEASE: start = 0. On finish = 0: rsp_valid <= 1, rsp_timeout <= 0, op_count += 1, go to RESP.
  - RESP: rsp_valid held with stable rsp_result and rsp_timeout until rsp_ready = 1. On that edge rsp_valid <= 0 and state goes to IDLE.
- finish is treated as a level and sampled once per cycle. An already-high finish on entering ISSUE is accepted on the first cycle.
- Timeout: the counter increments every cycle in ISSUE and RELEASE.
  - When it reaches TIMEOUT_CYCLES without the awaited finish level: start <= 0, rsp_result <= 0, rsp_timeout <= 1, rsp_valid <= 1, go to RESP.
  - op_count is not incremented on timeout.
- No bypass: a request is never accepted in the cycle a response is consumed. req_ready rises the cycle after the RESP handshake, so throughput is one operation per handshake round trip.
- Inputs req_* are ignored outside IDLE; out is ignored outside ISSUE.
- Latency with the team's adder: start rises 1 edge after the accepting edge; rsp_valid rises 9 edges after the accepting edge.
- Arithmetic is performed only by the adder; this block does no width or sign manipulation except the optional -0 normalisation.

Test Plan:
- Add: req_a = 16'h0005, req_b = 16'h0003, req_sub = 0 -> one start pulse; rsp_result = 16'h0008, rsp_timeout = 0, rsp_valid 9 edges after accept, op_count = 1.
- Subtract crossing zero: req_a = 16'h0003, req_b = 16'h0005, req_sub = 1 -> rsp_result = 16'h8002; INn1/INn2/sub constant throughout ISSUE.
- Negative zero: req_a = 16'h8000, req_b = 16'h8000, req_sub = 0, NORM_NEG_ZERO = 1 -> rsp_result = 16'h0000; with NORM_NEG_ZERO = 0 -> 16'h8000.
- Backpressure: hold rsp_ready = 0 for 10 cycles -> rsp_valid and rsp_result stable, req_ready = 0; a req_valid pulse in that window is not accepted, and the next op starts only after the rsp handshake.
- Timeout: stub holds finish = 0, TIMEOUT_CYCLES = 4 -> start falls after 4 ISSUE cycles; rsp_timeout = 1, rsp_result = 0, op_count unchanged. Repeat with finish stuck at 1 -> timeout raised from RELEASE.
- Reset mid-op: assert RST while in ISSUE -> start = 0 and rsp_valid = 0 combinationally; after release req_ready = 1, and a fresh request then completes correctly.
